// File: rtl/cmac_pkg.sv
// Shared definitions for the CMAC column scheduler.
// Contents: scheduler state encoding, default datapath widths, the
// error-counter width, and a helper that sizes the row-index port so that
// a single-row column still has a 1-bit index.
package cmac_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_W = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam int PSUM_W_DEF  = 24;
  localparam int EPROD_W_DEF = 16;
  localparam int ERR_CNT_W   = 16;

  function automatic int idx_width(input int rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

endpackage

// File: rtl/cmac_valid_pipe.sv
// Valid-bit delay line that mirrors the MAC column latency.
// Ports:
//   clk     - rising-edge clock
//   rst_n   - asynchronous active-low reset; flushes every stage
//   in_i    - valid bit entering the head (the activation fire strobe)
//   out_o   - valid bit leaving the tail, DEPTH cycles after entry
//   empty_o - no valid bit anywhere in the line
// Bubbles travel through as zeros, so out_o keeps the input spacing.
module cmac_valid_pipe #(
  parameter int DEPTH = 9
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_i,
  output logic out_o,
  output logic empty_o
);

  logic [DEPTH-1:0] pipe_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= {pipe_q[DEPTH-2:0], in_i};
    end
  end

  assign out_o   = pipe_q[DEPTH-1];
  assign empty_o = ~|pipe_q;

endmodule

// File: rtl/cmac_column_sched.sv
// Sequencer for one column of ROWS chained error-compensating MAC stages.
// Loads one weight per stage, streams k_len activation beats into the head,
// tracks the column latency with a valid pipe, and captures the tail partial
// sum with the tail's residual error product folded in.
// Ports:
//   clk, rst_n                  - clock, asynchronous active-low reset
//   start_i, k_len_i            - job request and beat count (latched on accept)
//   busy_o, done_o              - job in progress / one-cycle completion pulse
//   w_load_en_o, w_row_idx_o    - weight-load strobe and target stage
//   act_valid_i, act_ready_o    - activation handshake; act_fire_o = both high
//   psum_tail_i, err_tail_i     - last-stage partial sum and error product
//   err_sig_tail_i              - last-stage error flag
//   result_valid_o, result_data_o - compensated column result
//   err_count_o                 - tail error events in the current job
// Build option: CMAC_ERR_STATS_EN enables the saturating error-event
// counter; without it err_count_o is tied to zero.
//
// state     | meaning
// ----------+--------------------------------------------------------
// ST_IDLE   | waiting for start_i
// ST_LOAD_W | one weight per cycle, rows 0..ROWS-1
// ST_STREAM | accepting activation beats until k_len have fired
// ST_DRAIN  | waiting for the last beat to leave the valid pipe
// ST_DONE   | one-cycle done pulse
module cmac_column_sched
  import cmac_pkg::*;
#(
  parameter int ROWS    = 8,
  parameter int K_W     = 8,
  parameter int PSUM_W  = PSUM_W_DEF,
  parameter int EPROD_W = EPROD_W_DEF,
  localparam int IDX_W  = idx_width(ROWS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [K_W-1:0]       k_len_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 w_load_en_o,
  output logic [IDX_W-1:0]     w_row_idx_o,
  input  logic                 act_valid_i,
  output logic                 act_ready_o,
  output logic                 act_fire_o,
  input  logic [PSUM_W-1:0]    psum_tail_i,
  input  logic [EPROD_W-1:0]   err_tail_i,
  input  logic                 err_sig_tail_i,
  output logic                 result_valid_o,
  output logic [PSUM_W-1:0]    result_data_o,
  output logic [ERR_CNT_W-1:0] err_count_o
);

  state_e           state_q;
  logic [K_W-1:0]   k_q;
  logic [K_W-1:0]   beat_q;
  logic [IDX_W-1:0] row_q;
  logic             busy_q;
  logic             done_q;
  logic             w_load_q;
  logic             act_ready_q;

  logic             act_fire;
  logic             tail_valid;
  logic             pipe_empty;
  logic             result_valid_q;
  logic [PSUM_W-1:0] result_data_q;

  assign act_fire = act_valid_i & act_ready_q;

  // Outputs are set on the transition into the state that owns them, so
  // they line up with state_q without any decode after the flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      beat_q      <= '0;
      row_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      w_load_q    <= 1'b0;
      act_ready_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            k_q      <= k_len_i;
            beat_q   <= '0;
            row_q    <= '0;
            busy_q   <= 1'b1;
            w_load_q <= 1'b1;
            state_q  <= ST_LOAD_W;
          end
        end
        ST_LOAD_W: begin
          if (row_q == IDX_W'(ROWS - 1)) begin
            row_q    <= '0;
            w_load_q <= 1'b0;
            if (k_q == '0) begin
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              act_ready_q <= 1'b1;
              state_q     <= ST_STREAM;
            end
          end else begin
            row_q <= row_q + 1'b1;
          end
        end
        ST_STREAM: begin
          if (act_fire) begin
            if (beat_q == k_q - K_W'(1)) begin
              beat_q      <= '0;
              act_ready_q <= 1'b0;
              state_q     <= ST_DRAIN;
            end else begin
              beat_q <= beat_q + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (pipe_empty) begin
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Depth ROWS+1: one cycle per stage plus the head activation register.
  cmac_valid_pipe #(
    .DEPTH(ROWS + 1)
  ) u_valid_pipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .in_i   (act_fire),
    .out_o  (tail_valid),
    .empty_o(pipe_empty)
  );

  // Error product is unsigned; the sum wraps modulo 2^PSUM_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_valid_q <= 1'b0;
      result_data_q  <= '0;
    end else begin
      result_valid_q <= tail_valid;
      if (tail_valid) begin
        result_data_q <= psum_tail_i + PSUM_W'(err_tail_i);
      end
    end
  end

`ifdef CMAC_ERR_STATS_EN
  logic                 start_acc;
  logic [ERR_CNT_W-1:0] err_cnt_q;

  assign start_acc = (state_q == ST_IDLE) && start_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (start_acc) begin
      err_cnt_q <= '0;
    end else if (result_valid_q && err_sig_tail_i && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign err_count_o = err_cnt_q;
`else
  logic unused_err_sig;
  assign unused_err_sig = err_sig_tail_i;
  assign err_count_o    = '0;
`endif

  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign w_load_en_o    = w_load_q;
  assign w_row_idx_o    = row_q;
  assign act_ready_o    = act_ready_q;
  assign act_fire_o     = act_fire;
  assign result_valid_o = result_valid_q;
  assign result_data_o  = result_data_q;

endmodule

// File: tb/tb_cmac_column_sched.sv
module tb_cmac_column_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  k_len = 8'd0;
  logic        act_valid = 1'b0;
  logic [23:0] psum_tail = 24'd0;
  logic [15:0] err_tail = 16'd0;
  logic        err_sig_tail = 1'b0;

  logic        busy, done, w_load_en, act_ready, act_fire, result_valid;
  logic [2:0]  w_row_idx;
  logic [23:0] result_data;
  logic [15:0] err_count;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  int          fire_q[$];
  int          res_cyc_q[$];
  logic [23:0] res_dat_q[$];
  int          load_cyc_q[$];
  int          load_idx_q[$];
  int          done_cyc_q[$];

`ifdef CMAC_ERR_STATS_EN
  localparam logic [15:0] ERR_ONE = 16'd1;
`else
  localparam logic [15:0] ERR_ONE = 16'd0;
`endif

  cmac_column_sched #(
    .ROWS(8), .K_W(8), .PSUM_W(24), .EPROD_W(16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (start),
    .k_len_i       (k_len),
    .busy_o        (busy),
    .done_o        (done),
    .w_load_en_o   (w_load_en),
    .w_row_idx_o   (w_row_idx),
    .act_valid_i   (act_valid),
    .act_ready_o   (act_ready),
    .act_fire_o    (act_fire),
    .psum_tail_i   (psum_tail),
    .err_tail_i    (err_tail),
    .err_sig_tail_i(err_sig_tail),
    .result_valid_o(result_valid),
    .result_data_o (result_data),
    .err_count_o   (err_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n) begin
      if (act_fire) fire_q.push_back(cyc);
      if (result_valid) begin
        res_cyc_q.push_back(cyc);
        res_dat_q.push_back(result_data);
      end
      if (w_load_en) begin
        load_cyc_q.push_back(cyc);
        load_idx_q.push_back(int'(w_row_idx));
      end
      if (done) done_cyc_q.push_back(cyc);
    end
  end

  task automatic clear_logs();
    fire_q.delete();
    res_cyc_q.delete();
    res_dat_q.delete();
    load_cyc_q.delete();
    load_idx_q.delete();
    done_cyc_q.delete();
  endtask

  // pat bit i drives act_valid in the i-th STREAM cycle; 1 afterwards.
  // poke_at >= 0 raises start (with a different k_len) while busy.
  task automatic run_job(input logic [7:0] k, input int plen, input logic [15:0] pat,
                         input int poke_at, output bit ok);
    int idx;
    clear_logs();
    @(posedge clk); #1;
    start = 1'b1;
    k_len = k;
    @(posedge clk); #1;
    start = 1'b0;
    ok = 1'b0;
    idx = 0;
    for (int c = 0; c < 400; c++) begin
      if (c == poke_at) begin
        start = 1'b1;
        k_len = 8'd1;
      end else begin
        start = 1'b0;
      end
      if (act_ready) begin
        act_valid = (idx < plen) ? pat[idx] : 1'b1;
        idx++;
      end else begin
        act_valid = 1'b0;
      end
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    act_valid = 1'b0;
    k_len = 8'd0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    k_len = 8'd5;
    repeat (3) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
    n_cmp++; if (act_ready !== 1'b0) begin n_bad++; $display("FAIL reset_act_ready got %b want 0", act_ready); end
    n_cmp++; if (result_valid !== 1'b0) begin n_bad++; $display("FAIL reset_result_valid got %b want 0", result_valid); end
    n_cmp++; if (w_load_en !== 1'b0) begin n_bad++; $display("FAIL reset_w_load_en got %b want 0", w_load_en); end
    n_cmp++; if (err_count !== 16'd0) begin n_bad++; $display("FAIL reset_err_count got %h want 0", err_count); end
    @(posedge clk); #1;
    start = 1'b0;
    k_len = 8'd0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL post_reset_busy got %b want 0", busy); end
  endtask

  task automatic test_basic();
    bit ok;
    psum_tail = 24'h000100;
    err_tail = 16'h0005;
    err_sig_tail = 1'b0;
    run_job(8'd4, 0, 16'h0000, -1, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL basic_timeout got %b want 1", ok); end
    n_cmp++; if (load_cyc_q.size() != 8) begin n_bad++; $display("FAIL basic_load_count got %0d want 8", load_cyc_q.size()); end
    for (int i = 0; i < load_cyc_q.size(); i++) begin
      n_cmp++; if (load_idx_q[i] != i) begin n_bad++; $display("FAIL basic_load_idx[%0d] got %0d want %0d", i, load_idx_q[i], i); end
      n_cmp++; if (load_cyc_q[i] != load_cyc_q[0] + i) begin n_bad++; $display("FAIL basic_load_cyc[%0d] got %0d want %0d", i, load_cyc_q[i], load_cyc_q[0] + i); end
    end
    n_cmp++; if (fire_q.size() != 4) begin n_bad++; $display("FAIL basic_fire_count got %0d want 4", fire_q.size()); end
    if (fire_q.size() > 0 && load_cyc_q.size() == 8) begin
      n_cmp++; if (fire_q[0] != load_cyc_q[7] + 1) begin n_bad++; $display("FAIL basic_first_fire got %0d want %0d", fire_q[0], load_cyc_q[7] + 1); end
    end
    for (int i = 0; i < fire_q.size(); i++) begin
      n_cmp++; if (fire_q[i] != fire_q[0] + i) begin n_bad++; $display("FAIL basic_fire_cyc[%0d] got %0d want %0d", i, fire_q[i], fire_q[0] + i); end
    end
    n_cmp++; if (res_cyc_q.size() != 4) begin n_bad++; $display("FAIL basic_result_count got %0d want 4", res_cyc_q.size()); end
    for (int i = 0; i < res_cyc_q.size() && i < fire_q.size(); i++) begin
      n_cmp++; if (res_cyc_q[i] != fire_q[i] + 10) begin n_bad++; $display("FAIL basic_result_cyc[%0d] got %0d want %0d", i, res_cyc_q[i], fire_q[i] + 10); end
      n_cmp++; if (res_dat_q[i] !== 24'h000105) begin n_bad++; $display("FAIL basic_result_data[%0d] got %h want 000105", i, res_dat_q[i]); end
    end
    n_cmp++; if (done_cyc_q.size() != 1) begin n_bad++; $display("FAIL basic_done_count got %0d want 1", done_cyc_q.size()); end
    if (done_cyc_q.size() > 0 && fire_q.size() == 4) begin
      n_cmp++; if (done_cyc_q[0] != fire_q[3] + 11) begin n_bad++; $display("FAIL basic_done_cyc got %0d want %0d", done_cyc_q[0], fire_q[3] + 11); end
    end
    n_cmp++; if (err_count !== 16'd0) begin n_bad++; $display("FAIL basic_err_count got %h want 0", err_count); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_after got %b want 0", busy); end
  endtask

  task automatic test_bubbles();
    bit ok;
    int offs[4] = '{0, 2, 3, 5};
    psum_tail = 24'h123456;
    err_tail = 16'h0001;
    err_sig_tail = 1'b0;
    // act_valid sequence 1,0,1,1,0,1 (bit 0 first)
    run_job(8'd4, 6, 16'h002D, -1, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL bubble_timeout got %b want 1", ok); end
    n_cmp++; if (fire_q.size() != 4) begin n_bad++; $display("FAIL bubble_fire_count got %0d want 4", fire_q.size()); end
    for (int i = 0; i < fire_q.size() && i < 4; i++) begin
      n_cmp++; if (fire_q[i] != fire_q[0] + offs[i]) begin n_bad++; $display("FAIL bubble_fire_cyc[%0d] got %0d want %0d", i, fire_q[i], fire_q[0] + offs[i]); end
    end
    n_cmp++; if (res_cyc_q.size() != 4) begin n_bad++; $display("FAIL bubble_result_count got %0d want 4", res_cyc_q.size()); end
    for (int i = 0; i < res_cyc_q.size() && i < fire_q.size(); i++) begin
      n_cmp++; if (res_cyc_q[i] != fire_q[i] + 10) begin n_bad++; $display("FAIL bubble_result_cyc[%0d] got %0d want %0d", i, res_cyc_q[i], fire_q[i] + 10); end
      n_cmp++; if (res_dat_q[i] !== 24'h123457) begin n_bad++; $display("FAIL bubble_result_data[%0d] got %h want 123457", i, res_dat_q[i]); end
    end
    if (done_cyc_q.size() == 1 && fire_q.size() == 4) begin
      n_cmp++; if (done_cyc_q[0] != fire_q[3] + 11) begin n_bad++; $display("FAIL bubble_done_cyc got %0d want %0d", done_cyc_q[0], fire_q[3] + 11); end
    end else begin
      n_cmp++; n_bad++;
      $display("FAIL bubble_done got %0d pulses want 1", done_cyc_q.size());
    end
  endtask

  task automatic test_compensation();
    bit ok;
    psum_tail = 24'hFFFFF0;
    err_tail = 16'h0020;
    err_sig_tail = 1'b1;
    run_job(8'd1, 0, 16'h0000, -1, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL comp_timeout got %b want 1", ok); end
    n_cmp++; if (res_cyc_q.size() != 1) begin n_bad++; $display("FAIL comp_result_count got %0d want 1", res_cyc_q.size()); end
    if (res_dat_q.size() > 0) begin
      n_cmp++; if (res_dat_q[0] !== 24'h000010) begin n_bad++; $display("FAIL comp_result_data got %h want 000010", res_dat_q[0]); end
    end
    n_cmp++; if (err_count !== ERR_ONE) begin n_bad++; $display("FAIL comp_err_count got %h want %h", err_count, ERR_ONE); end
  endtask

  task automatic test_kzero();
    bit ok;
    err_sig_tail = 1'b0;
    run_job(8'd0, 0, 16'h0000, -1, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL kzero_timeout got %b want 1", ok); end
    n_cmp++; if (load_cyc_q.size() != 8) begin n_bad++; $display("FAIL kzero_load_count got %0d want 8", load_cyc_q.size()); end
    n_cmp++; if (fire_q.size() != 0) begin n_bad++; $display("FAIL kzero_fire_count got %0d want 0", fire_q.size()); end
    n_cmp++; if (res_cyc_q.size() != 0) begin n_bad++; $display("FAIL kzero_result_count got %0d want 0", res_cyc_q.size()); end
    if (done_cyc_q.size() == 1 && load_cyc_q.size() == 8) begin
      n_cmp++; if (done_cyc_q[0] != load_cyc_q[7] + 1) begin n_bad++; $display("FAIL kzero_done_cyc got %0d want %0d", done_cyc_q[0], load_cyc_q[7] + 1); end
    end else begin
      n_cmp++; n_bad++;
      $display("FAIL kzero_done got %0d pulses want 1", done_cyc_q.size());
    end
    // cleared on the accepted start of this job
    n_cmp++; if (err_count !== 16'd0) begin n_bad++; $display("FAIL kzero_err_count got %h want 0", err_count); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    psum_tail = 24'h000A00;
    err_tail = 16'h00FF;
    err_sig_tail = 1'b0;
    run_job(8'd2, 0, 16'h0000, 2, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL b2b_a_timeout got %b want 1", ok); end
    n_cmp++; if (fire_q.size() != 2) begin n_bad++; $display("FAIL b2b_a_fire_count got %0d want 2", fire_q.size()); end
    n_cmp++; if (res_cyc_q.size() != 2) begin n_bad++; $display("FAIL b2b_a_result_count got %0d want 2", res_cyc_q.size()); end
    run_job(8'd3, 0, 16'h0000, 12, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL b2b_b_timeout got %b want 1", ok); end
    n_cmp++; if (fire_q.size() != 3) begin n_bad++; $display("FAIL b2b_b_fire_count got %0d want 3", fire_q.size()); end
    n_cmp++; if (res_cyc_q.size() != 3) begin n_bad++; $display("FAIL b2b_b_result_count got %0d want 3", res_cyc_q.size()); end
    if (res_dat_q.size() > 2) begin
      n_cmp++; if (res_dat_q[2] !== 24'h000AFF) begin n_bad++; $display("FAIL b2b_b_result_data got %h want 000AFF", res_dat_q[2]); end
    end
    n_cmp++; if (done_cyc_q.size() != 1) begin n_bad++; $display("FAIL b2b_b_done_count got %0d want 1", done_cyc_q.size()); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    clear_logs();
    @(posedge clk); #1;
    start = 1'b1;
    k_len = 8'd20;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      act_valid = 1'b1;
      @(negedge clk);
      if (fire_q.size() >= 2) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL rstmid_reach_stream got %b want 1", seen); end
    @(posedge clk); #1;
    rst_n = 1'b0;
    act_valid = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy got %b want 0", busy); end
    @(negedge clk);
    n_cmp++; if (act_ready !== 1'b0) begin n_bad++; $display("FAIL rstmid_act_ready got %b want 0", act_ready); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rstmid_done got %b want 0", done); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_logs();
    repeat (20) @(posedge clk);
    #1;
    n_cmp++; if (res_cyc_q.size() != 0) begin n_bad++; $display("FAIL rstmid_stale_results got %0d want 0", res_cyc_q.size()); end
    n_cmp++; if (done_cyc_q.size() != 0) begin n_bad++; $display("FAIL rstmid_done_after got %0d want 0", done_cyc_q.size()); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy_after got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bubbles();
    test_compensation();
    test_kzero();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
